// File: rtl/pic_exec_unit.sv
// Execute stage: decodes the instruction byte, runs the 8-bit ALU against W and holds C/Z.
// Result/decode are combinational in the input cycle; flags land on the next edge. No backpressure.
module pic_exec_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       inst_reg,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] ans,
    output logic             d,
    output logic             switch_a_m,
    output logic [3:0]       inst,
    output logic [2:0]       bit_number,
    output logic             carry,
    output logic             zero
);

    logic             d_dec;
    logic             movf_z;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic             z_en;

    assign bit_number = inst_reg[3:1];

    always_comb begin
        inst       = 4'hF;
        d_dec      = 1'b0;
        switch_a_m = 1'b0;
        movf_z     = 1'b0;
        case (inst_reg[7:6])
            2'b00: begin
                // Opcode 0000 covers both MOVWF (d=1) and NOP (d=0), so d passes through.
                d_dec = inst_reg[1];
                case (inst_reg[5:2])
                    4'b0000: inst = 4'hF;
                    4'b0001: inst = 4'hC;
                    4'b0010: inst = 4'h2;
                    4'b0011: inst = 4'h8;
                    4'b0100: inst = 4'h4;
                    4'b0101: inst = 4'h3;
                    4'b0110: inst = 4'h5;
                    4'b0111: inst = 4'h1;
                    4'b1000: begin
                        inst   = 4'h0;
                        movf_z = 1'b1;
                    end
                    4'b1001: inst = 4'h6;
                    4'b1010: inst = 4'h7;
                    4'b1100: inst = 4'hA;
                    4'b1101: inst = 4'h9;
                    4'b1110: inst = 4'hB;
                    default: begin
                        inst  = 4'hF;
                        d_dec = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                if (inst_reg[5:4] == 2'b00) begin
                    inst  = 4'hD;
                    d_dec = 1'b1;
                end else if (inst_reg[5:4] == 2'b01) begin
                    inst  = 4'hE;
                    d_dec = 1'b1;
                end
            end
            2'b11: begin
                switch_a_m = 1'b1;
                if (inst_reg[5:4] == 2'b00)        inst = 4'h0;
                else if (inst_reg[5:1] == 5'b11000) inst = 4'h4;
                else if (inst_reg[5:1] == 5'b11001) inst = 4'h3;
                else if (inst_reg[5:1] == 5'b11010) inst = 4'h5;
                else if (inst_reg[5:2] == 4'b1110)  inst = 4'h2;
                else if (inst_reg[5:2] == 4'b1111)  inst = 4'h1;
                else                                switch_a_m = 1'b0;
            end
            default: inst = 4'hF;
        endcase
    end

    assign a   = w;
    assign b   = switch_a_m ? k : f;
    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        res = '0;
        case (inst)
            4'h0: res = b;
            4'h1: res = sum[WIDTH-1:0];
            4'h2: res = b - a;
            4'h3: res = a & b;
            4'h4: res = a | b;
            4'h5: res = a ^ b;
            4'h6: res = ~b;
            4'h7: res = b + WIDTH'(1);
            4'h8: res = b - WIDTH'(1);
            4'h9: res = {b[WIDTH-2:0], carry};
            4'hA: res = {carry, b[WIDTH-1:1]};
            4'hB: res = {b[3:0], b[7:4]};
            4'hC: res = '0;
            4'hD: res = b & ~(WIDTH'(1) << bit_number);
            4'hE: res = b | (WIDTH'(1) << bit_number);
            default: res = a;
        endcase
    end

    // Held reset suppresses write-back by zeroing the result and destination.
    assign ans = reset ? res : '0;
    assign d   = reset ? d_dec : 1'b0;

    always_comb begin
        case (inst)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC: z_en = 1'b1;
            default: z_en = movf_z;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (inst)
                4'h1: carry <= sum[WIDTH];
                4'h2: carry <= (b >= a);
                4'h9: carry <= b[WIDTH-1];
                4'hA: carry <= b[0];
                default: carry <= carry;
            endcase
            if (z_en) zero <= (res == '0);
        end
    end

endmodule

// File: tb/tb_pic_exec_unit.sv
// Directed-vector bench for pic_exec_unit with a queued scoreboard and a negedge monitor.
module tb_pic_exec_unit;

    typedef struct packed {
        logic       rst;
        logic [7:0] ir;
        logic [7:0] f;
        logic [7:0] k;
        logic [7:0] w;
        logic [7:0] e_ans;
        logic       e_d;
        logic       e_sam;
        logic [3:0] e_inst;
        logic [2:0] e_bn;
        logic       e_c;
        logic       e_z;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [7:0] inst_reg;
    logic [7:0] f;
    logic [7:0] k;
    logic [7:0] w;
    logic [7:0] ans;
    logic       d;
    logic       switch_a_m;
    logic [3:0] inst;
    logic [2:0] bit_number;
    logic       carry;
    logic       zero;

    logic       vec_vld;
    vec_t       vecs[$];
    vec_t       sb[$];
    int         n_vec;
    int         n_miss;

    pic_exec_unit #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_reg   (inst_reg),
        .f          (f),
        .k          (k),
        .w          (w),
        .ans        (ans),
        .d          (d),
        .switch_a_m (switch_a_m),
        .inst       (inst),
        .bit_number (bit_number),
        .carry      (carry),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [7:0] ir, input logic [7:0] vf,
                       input logic [7:0] vk, input logic [7:0] vw, input logic [7:0] e_ans,
                       input logic e_d, input logic e_sam, input logic [3:0] e_inst,
                       input logic [2:0] e_bn, input logic e_c, input logic e_z);
        vec_t v;
        v = '{rst, ir, vf, vk, vw, e_ans, e_d, e_sam, e_inst, e_bn, e_c, e_z};
        vecs.push_back(v);
    endtask

    task automatic chk(input int idx, input string name, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // Flag columns are the values visible during the vector, i.e. the result of earlier edges.
    initial begin
        //   rst ir     f      k      w      ans    d  sam inst  bn  c  z
        add(0, 8'h1E, 8'd10, 8'h00, 8'd250, 8'h00, 0, 0, 4'h1, 7, 0, 0);
        add(1, 8'hC0, 8'h00, 8'd10, 8'h00, 8'd10, 0, 1, 4'h0, 0, 0, 0);
        add(1, 8'h1E, 8'd10, 8'h00, 8'd250, 8'h04, 1, 0, 4'h1, 7, 0, 0);
        add(1, 8'h0A, 8'd5,  8'h00, 8'd5,  8'h00, 1, 0, 4'h2, 5, 1, 0);
        add(1, 8'h0A, 8'd1,  8'h00, 8'd2,  8'hFF, 1, 0, 4'h2, 5, 1, 1);
        add(1, 8'h56, 8'h00, 8'h00, 8'h00, 8'h08, 1, 0, 4'hE, 3, 0, 0);
        add(1, 8'h46, 8'hFF, 8'h00, 8'h00, 8'hF7, 1, 0, 4'hD, 3, 0, 0);
        add(1, 8'h1E, 8'h80, 8'h00, 8'h80, 8'h00, 1, 0, 4'h1, 7, 0, 0);
        add(1, 8'h36, 8'h80, 8'h00, 8'h00, 8'h01, 1, 0, 4'h9, 3, 1, 1);
        add(1, 8'h32, 8'h01, 8'h00, 8'h00, 8'h80, 1, 0, 4'hA, 1, 1, 1);
        add(1, 8'h3A, 8'h3C, 8'h00, 8'h00, 8'hC3, 1, 0, 4'hB, 5, 1, 1);
        add(1, 8'h00, 8'h12, 8'h00, 8'h55, 8'h55, 0, 0, 4'hF, 0, 1, 1);
        add(1, 8'h2C, 8'h12, 8'h00, 8'h66, 8'h66, 0, 0, 4'hF, 6, 1, 1);
        add(1, 8'h02, 8'h12, 8'h00, 8'h77, 8'h77, 1, 0, 4'hF, 1, 1, 1);
        add(1, 8'hF0, 8'h00, 8'h0F, 8'hF0, 8'hFF, 0, 1, 4'h4, 0, 1, 1);
        add(1, 8'hF2, 8'h00, 8'h0F, 8'hF0, 8'h00, 0, 1, 4'h3, 1, 1, 0);
        add(1, 8'hF4, 8'h00, 8'hAA, 8'h55, 8'hFF, 0, 1, 4'h5, 2, 1, 1);
        add(1, 8'hF8, 8'h00, 8'h03, 8'h05, 8'hFE, 0, 1, 4'h2, 4, 1, 0);
        add(1, 8'hFC, 8'h00, 8'h01, 8'hFF, 8'h00, 0, 1, 4'h1, 6, 0, 0);
        add(1, 8'h20, 8'h05, 8'h00, 8'h00, 8'h05, 0, 0, 4'h0, 0, 1, 1);
        add(1, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 4'h0, 0, 1, 0);
        add(1, 8'h80, 8'h00, 8'h00, 8'h12, 8'h12, 0, 0, 4'hF, 0, 1, 0);
        add(1, 8'h06, 8'h33, 8'h00, 8'h00, 8'h00, 1, 0, 4'hC, 3, 1, 0);
        add(1, 8'h26, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 4'h6, 3, 1, 1);
        add(1, 8'h2A, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 4'h7, 5, 1, 1);
        add(1, 8'h0E, 8'h01, 8'h00, 8'h00, 8'h00, 1, 0, 4'h8, 7, 1, 1);
        add(1, 8'h60, 8'h09, 8'h00, 8'h44, 8'h44, 0, 0, 4'hF, 0, 1, 1);
        add(0, 8'h1E, 8'h01, 8'h00, 8'h01, 8'h00, 0, 0, 4'h1, 7, 1, 1);
        add(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 4'hF, 0, 0, 0);

        n_vec    = 0;
        n_miss   = 0;
        vec_vld  = 1'b0;
        reset    = 1'b0;
        inst_reg = 8'h00;
        f        = 8'h00;
        k        = 8'h00;
        w        = 8'h00;
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            inst_reg = vecs[i].ir;
            f        = vecs[i].f;
            k        = vecs[i].k;
            w        = vecs[i].w;
            sb.push_back(vecs[i]);
            vec_vld  = 1'b1;
            @(posedge clk);
            #1;
        end
        vec_vld = 1'b0;
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        if (n_vec != vecs.size()) begin
            n_miss++;
            $display("FAIL count: got %0d checked expected %0d", n_vec, vecs.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    always @(negedge clk) begin
        if (vec_vld) begin
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL underflow: got empty scoreboard expected an entry");
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk(n_vec, "ans",        ans,               e.e_ans);
                chk(n_vec, "d",          {7'd0, d},          {7'd0, e.e_d});
                chk(n_vec, "switch_a_m", {7'd0, switch_a_m}, {7'd0, e.e_sam});
                chk(n_vec, "inst",       {4'd0, inst},       {4'd0, e.e_inst});
                chk(n_vec, "bit_number", {5'd0, bit_number}, {5'd0, e.e_bn});
                chk(n_vec, "carry",      {7'd0, carry},      {7'd0, e.e_c});
                chk(n_vec, "zero",       {7'd0, zero},       {7'd0, e.e_z});
                n_vec++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
